apb_sensor_poller: RTL and testbench

APB_SENSOR_POLLER -- requirements
Module: apb_sensor_poller

---
 rtl/apb_poller_pkg.sv | 16 +
 rtl/apb_if.sv | 21 ++
 rtl/apb_timeout_counter.sv | 31 +++
 rtl/apb_sensor_poller.sv | 119 +++++++++++
 tb/tb_apb_sensor_poller.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_poller_pkg.sv
// Shared types for the APB sensor poller: FSM state encoding and sizing helper.
package apb_poller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    NEXT   = 2'd3
  } apb_poll_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle with 8-bit address and 16-bit data.
interface apb_if;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  modport requester (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport completer (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS-phase cycles; expired marks the last cycle a transfer may wait.
module apb_timeout_counter
  import apb_poller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = clog2_min1(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // count holds the number of ACCESS cycles already spent before the current one
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_sensor_poller.sv
// Periodically sweeps NUM_REGS 16-bit APB registers and caches the last good value of each.
module apb_sensor_poller
  import apb_poller_pkg::*;
#(
  parameter int          NUM_REGS       = 8,
  parameter logic [7:0]  BASE_ADDR      = 8'h10,
  parameter int          POLL_INTERVAL  = 1000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  apb_if.requester                 apb,
  input  logic                     start,
  output logic                     busy,
  output logic                     sweep_done,
  output logic [NUM_REGS-1:0][15:0] reg_value,
  output logic [NUM_REGS-1:0]      reg_valid,
  output logic                     err_slverr,
  output logic                     err_timeout,
  input  logic                     err_clear,
  output logic [1:0]               dbg_state
);

  localparam int IDX_W = clog2_min1(NUM_REGS);
  localparam int ICW   = clog2_min1(POLL_INTERVAL);

  // Handshake: a transfer completes in the ACCESS cycle where pready is high;
  // pslverr is only meaningful in that same cycle.

  apb_poll_state_t  state, next_state;
  logic [IDX_W-1:0] index, index_nxt;
  logic [ICW-1:0]   icnt;
  logic [7:0]       paddr_q;
  logic             last, interval_hit, expired;
  logic             slv_set, to_set;

  assign last         = (index == IDX_W'(NUM_REGS - 1));
  assign interval_hit = (icnt == ICW'(POLL_INTERVAL - 1));
  assign slv_set      = (state == ACCESS) && apb.pready && apb.pslverr;
  assign to_set       = (state == ACCESS) && !apb.pready && expired;

  assign busy        = (state != IDLE);
  assign dbg_state   = state;
  assign apb.psel    = (state == SETUP) || (state == ACCESS);
  assign apb.penable = (state == ACCESS);
  assign apb.pwrite  = 1'b0;
  assign apb.pwdata  = 16'h0000;
  assign apb.paddr   = paddr_q;

  apb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (pclk),
    .rst_n  (preset_n),
    .clear  (state != ACCESS),
    .enable (state == ACCESS),
    .expired(expired)
  );

  always_comb begin
    next_state = state;
    index_nxt  = '0;
    case (state)
      IDLE:    if (start || interval_hit) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (apb.pready || expired) next_state = NEXT;
      NEXT: begin
        next_state = last ? IDLE : SETUP;
        index_nxt  = index + 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state      <= IDLE;
      index      <= '0;
      icnt       <= '0;
      paddr_q    <= 8'h00;
      sweep_done <= 1'b0;
    end else begin
      state      <= next_state;
      sweep_done <= (state == NEXT) && last;
      if (state == IDLE) index <= '0;
      else if (state == NEXT && !last) index <= index_nxt;
      // Address is registered on entry to SETUP so it stays stable through ACCESS
      if (next_state == SETUP) paddr_q <= BASE_ADDR + (8'(index_nxt) << 1);
      if (state == NEXT && last) icnt <= '0;
      else if (state == IDLE && next_state == IDLE && !interval_hit) icnt <= icnt + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      reg_value <= '0;
      reg_valid <= '0;
    end else if (state == ACCESS) begin
      if (apb.pready && !apb.pslverr) begin
        reg_value[index] <= apb.prdata;
        reg_valid[index] <= 1'b1;
      end else if (apb.pready || expired) begin
        reg_valid[index] <= 1'b0;
      end
    end
  end

  // A same-cycle set beats err_clear
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      err_slverr  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (slv_set)        err_slverr <= 1'b1;
      else if (err_clear) err_slverr <= 1'b0;
      if (to_set)         err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_sensor_poller.sv
// Directed bench for apb_sensor_poller with a configurable APB completer model.
module tb_apb_sensor_poller;
  import apb_poller_pkg::*;

  localparam int NR = 4;
  localparam int PI = 20;
  localparam int TO = 8;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  logic start = 1'b0;
  logic err_clear = 1'b0;
  logic busy, sweep_done, err_slverr, err_timeout;
  logic [NR-1:0][15:0] reg_value;
  logic [NR-1:0] reg_valid;
  logic [1:0] dbg_state;

  int compared = 0;
  int mismatched = 0;

  apb_if apb_bus ();

  apb_sensor_poller #(
    .NUM_REGS(NR), .BASE_ADDR(8'h10), .POLL_INTERVAL(PI), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .apb(apb_bus), .start(start),
    .busy(busy), .sweep_done(sweep_done), .reg_value(reg_value),
    .reg_valid(reg_valid), .err_slverr(err_slverr), .err_timeout(err_timeout),
    .err_clear(err_clear), .dbg_state(dbg_state)
  );

  always #5 pclk = ~pclk;

  // Completer model: per-register wait states, slave error or no response at all
  logic [15:0] data_base = 16'hA000;
  int wait_cfg[NR];
  logic [NR-1:0] slverr_cfg = '0;
  logic [NR-1:0] hang_cfg = '0;
  int acc_cnt = 0;
  logic [7:0] off;
  logic [1:0] ri;

  assign off = apb_bus.paddr - 8'h10;
  assign ri  = off[2:1];
  assign apb_bus.pready  = apb_bus.psel && apb_bus.penable && !hang_cfg[ri] && (acc_cnt == wait_cfg[ri]);
  assign apb_bus.prdata  = data_base + 16'(ri);
  assign apb_bus.pslverr = apb_bus.pready && slverr_cfg[ri];

  always @(posedge pclk) begin
    if (apb_bus.psel && apb_bus.penable && !apb_bus.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  // Bus monitor: SETUP addresses in order, ACCESS cycles per register, address stability
  logic [7:0] addr_log[$];
  logic [7:0] exp_q[$];
  int pen_cnt[NR];
  logic [7:0] cur_addr = 8'h00;
  bit addr_moved = 0;

  always @(negedge pclk) begin
    if (preset_n) begin
      if (apb_bus.psel && !apb_bus.penable) begin
        addr_log.push_back(apb_bus.paddr);
        cur_addr = apb_bus.paddr;
      end
      if (apb_bus.psel && apb_bus.penable) begin
        pen_cnt[ri] = pen_cnt[ri] + 1;
        if (apb_bus.paddr !== cur_addr) addr_moved = 1;
      end
    end
  end

  task automatic clear_log();
    addr_log.delete();
    for (int i = 0; i < NR; i++) pen_cnt[i] = 0;
    addr_moved = 0;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset_n = 1'b0;
    start = 1'b0;
    err_clear = 1'b0;
    data_base = 16'hA000;
    slverr_cfg = '0;
    hang_cfg = '0;
    for (int i = 0; i < NR; i++) wait_cfg[i] = 0;
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    clear_log();
  endtask

  task automatic run_sweep(output int cycles);
    start = 1'b1;
    cycles = 0;
    do begin
      @(negedge pclk);
      start = 1'b0;
      cycles++;
    end while (!sweep_done && cycles < 200);
    if (!sweep_done) begin
      compared++; mismatched++;
      $display("FAIL sweep_wait: sweep_done not seen within %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    @(negedge pclk);
    preset_n = 1'b0;
    repeat (2) @(negedge pclk);
    compared++;
    if ({apb_bus.psel, apb_bus.penable, apb_bus.pwrite, busy, sweep_done} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b want 00000", {apb_bus.psel, apb_bus.penable, apb_bus.pwrite, busy, sweep_done});
    end
    compared++;
    if (apb_bus.paddr !== 8'h00 || apb_bus.pwdata !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_bus: paddr %h pwdata %h want 00 0000", apb_bus.paddr, apb_bus.pwdata);
    end
    compared++;
    if (reg_value !== '0 || reg_valid !== '0 || err_slverr !== 1'b0 || err_timeout !== 1'b0 || dbg_state !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_regs: value %h valid %b errs %b%b state %0d want all zero",
               reg_value, reg_valid, err_slverr, err_timeout, dbg_state);
    end
    preset_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    int cyc;
    do_reset();
    run_sweep(cyc);
    compared++;
    if (cyc !== 13) begin
      mismatched++; $display("FAIL zw_latency: got %0d want 13", cyc);
    end
    exp_q = '{8'h10, 8'h12, 8'h14, 8'h16};
    compared++;
    if (addr_log.size() != exp_q.size()) begin
      mismatched++; $display("FAIL zw_addr_count: got %0d want %0d", addr_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        compared++;
        if (addr_log[i] !== exp_q[i]) begin
          mismatched++; $display("FAIL zw_addr[%0d]: got %h want %h", i, addr_log[i], exp_q[i]);
        end
      end
    end
    compared++;
    if (reg_value !== {16'hA003, 16'hA002, 16'hA001, 16'hA000}) begin
      mismatched++; $display("FAIL zw_value: got %h want a003a002a001a000", reg_value);
    end
    compared++;
    if (reg_valid !== 4'hF || busy !== 1'b0) begin
      mismatched++; $display("FAIL zw_valid_busy: got %b %b want 1111 0", reg_valid, busy);
    end
    @(negedge pclk);
    compared++;
    if (sweep_done !== 1'b0) begin
      mismatched++; $display("FAIL zw_done_pulse: got %b want 0", sweep_done);
    end
  endtask

  task automatic test_wait_states();
    int cyc;
    do_reset();
    wait_cfg[1] = 3;
    data_base = 16'hC000;
    run_sweep(cyc);
    compared++;
    if (pen_cnt[1] !== 4) begin
      mismatched++; $display("FAIL ws_penable_cycles: got %0d want 4", pen_cnt[1]);
    end
    compared++;
    if (addr_moved !== 1'b0 || addr_log.size() < 2 || addr_log[1] !== 8'h12) begin
      mismatched++; $display("FAIL ws_addr_stable: moved %0d log_size %0d", addr_moved, addr_log.size());
    end
    compared++;
    if (reg_value[1] !== 16'hC001 || reg_valid !== 4'hF) begin
      mismatched++; $display("FAIL ws_capture: got %h %b want c001 1111", reg_value[1], reg_valid);
    end
    compared++;
    if (cyc !== 16) begin
      mismatched++; $display("FAIL ws_latency: got %0d want 16", cyc);
    end
  endtask

  task automatic test_slverr();
    int cyc;
    do_reset();
    run_sweep(cyc);
    data_base = 16'hB000;
    slverr_cfg = 4'b0100;
    clear_log();
    run_sweep(cyc);
    compared++;
    if (reg_valid !== 4'b1011 || err_slverr !== 1'b1 || err_timeout !== 1'b0) begin
      mismatched++; $display("FAIL se_flags: valid %b slverr %b timeout %b want 1011 1 0", reg_valid, err_slverr, err_timeout);
    end
    compared++;
    if (reg_value !== {16'hB003, 16'hA002, 16'hB001, 16'hB000}) begin
      mismatched++; $display("FAIL se_values: got %h want b003a002b001b000", reg_value);
    end
    compared++;
    if (addr_log.size() != 4 || addr_log[3] !== 8'h16) begin
      mismatched++; $display("FAIL se_continue: %0d transfers logged want 4 ending at 16", addr_log.size());
    end
    err_clear = 1'b1;
    @(negedge pclk);
    err_clear = 1'b0;
    compared++;
    if (err_slverr !== 1'b0) begin
      mismatched++; $display("FAIL se_clear: got %b want 0", err_slverr);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    hang_cfg = 4'b0001;
    err_clear = 1'b1;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge pclk);
      start = 1'b0;
      n++;
    end while (dbg_state !== 2'd3 && n < 40);
    compared++;
    if (err_timeout !== 1'b1 || apb_bus.psel !== 1'b0) begin
      mismatched++; $display("FAIL to_set_wins: timeout %b psel %b want 1 0", err_timeout, apb_bus.psel);
    end
    compared++;
    if (pen_cnt[0] !== TO) begin
      mismatched++; $display("FAIL to_access_cycles: got %0d want %0d", pen_cnt[0], TO);
    end
    @(negedge pclk);
    compared++;
    if (err_timeout !== 1'b0) begin
      mismatched++; $display("FAIL to_clear: got %b want 0", err_timeout);
    end
    err_clear = 1'b0;
    n = 0;
    while (!sweep_done && n < 100) begin
      @(negedge pclk);
      n++;
    end
    compared++;
    if (!sweep_done || reg_valid !== 4'b1110 || reg_value[3] !== 16'hA003) begin
      mismatched++; $display("FAIL to_continue: done %b valid %b r3 %h want 1 1110 a003", sweep_done, reg_valid, reg_value[3]);
    end
  endtask

  task automatic test_interval();
    int n;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge pclk);
        n++;
      end while (!apb_bus.psel && n < 100);
      compared++;
      if (n !== PI) begin
        mismatched++; $display("FAIL interval_%0d: psel after %0d cycles want %0d", k, n, PI);
      end
      n = 0;
      while (!sweep_done && n < 100) begin
        @(negedge pclk);
        n++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    hang_cfg = 4'b0001;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge pclk);
      start = 1'b0;
      n++;
    end while (dbg_state !== 2'd2 && n < 10);
    #2;
    preset_n = 1'b0;
    #1;
    compared++;
    if ({apb_bus.psel, apb_bus.penable, busy, sweep_done} !== 4'b0 || apb_bus.paddr !== 8'h00) begin
      mismatched++; $display("FAIL async_reset_bus: ctrl %b paddr %h want 0000 00",
                             {apb_bus.psel, apb_bus.penable, busy, sweep_done}, apb_bus.paddr);
    end
    compared++;
    if (dbg_state !== 2'd0 || reg_valid !== '0 || reg_value !== '0) begin
      mismatched++; $display("FAIL async_reset_state: state %0d valid %b", dbg_state, reg_valid);
    end
    @(negedge pclk);
    hang_cfg = '0;
    preset_n = 1'b1;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!apb_bus.psel && n < 100);
    compared++;
    if (n !== PI) begin
      mismatched++; $display("FAIL post_reset_interval: psel after %0d want %0d", n, PI);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_interval();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
